// File: rtl/systolic_feeder.sv
// Feeder for a 4x4 output-stationary MAC array: holds A/B, streams skewed operands.
// Optional FEEDER_JOB_CNT_EN adds a 16-bit completed-job counter output.
module systolic_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  load_sel,
    input  logic [1:0]            load_row,
    input  logic [DATA_WIDTH*N-1:0] load_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  arr_clr,
    output logic                  we,
    output logic [DATA_WIDTH*N-1:0] a_out,
`ifdef FEEDER_JOB_CNT_EN
    output logic [DATA_WIDTH*N-1:0] b_out,
    output logic [15:0]           job_cnt
`else
    output logic [DATA_WIDTH*N-1:0] b_out
`endif
);

    localparam int SKEW_CYCLES = 3 * N - 2;
    localparam int T_W         = $clog2(SKEW_CYCLES);
    localparam logic [T_W-1:0] T_LAST = T_W'(SKEW_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_e;

    typedef logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mat_t;

    state_e                  state_q, state_d;
    logic [T_W-1:0]          t_q, t_d;
    mat_t                    a_q, a_d, b_q, b_d;
    logic                    done_q, done_d;
    logic                    arr_clr_q, arr_clr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH*N-1:0] a_out_q, a_out_d;
    logic [DATA_WIDTH*N-1:0] b_out_q, b_out_d;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_d     = a_q;
        b_d     = b_q;

        if (load_valid && state_q == S_IDLE) begin
            if (load_sel) b_d[load_row] = load_data;
            else          a_d[load_row] = load_data;
        end

        case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR: begin
                state_d = S_STREAM;
                t_d     = '0;
            end
            S_STREAM: begin
                if (t_q == T_LAST) state_d = S_FLUSH;
                else               t_d     = t_q + 1'b1;
            end
            S_FLUSH:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered, aligned with the state they describe.
    always_comb begin
        done_d    = (state_d == S_DONE);
        arr_clr_d = (state_d == S_CLEAR);
        we_d      = (state_d == S_STREAM);
        a_out_d   = '0;
        b_out_d   = '0;
        if (state_d == S_STREAM) begin
            for (int lane = 0; lane < N; lane++) begin
                for (int kk = 0; kk < N; kk++) begin
                    if (t_d == T_W'(lane + kk)) begin
                        a_out_d[lane*DATA_WIDTH +: DATA_WIDTH] = a_q[lane][kk];
                        b_out_d[lane*DATA_WIDTH +: DATA_WIDTH] = b_q[kk][lane];
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: the operand storage is reset as well, because a job launched after reset must stream zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            t_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            done_q    <= 1'b0;
            arr_clr_q <= 1'b0;
            we_q      <= 1'b0;
            a_out_q   <= '0;
            b_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            a_q       <= a_d;
            b_q       <= b_d;
            done_q    <= done_d;
            arr_clr_q <= arr_clr_d;
            we_q      <= we_d;
            a_out_q   <= a_out_d;
            b_out_q   <= b_out_d;
        end
    end

`ifdef FEEDER_JOB_CNT_EN
    logic [15:0] job_cnt_q, job_cnt_d;

    always_comb begin
        job_cnt_d = job_cnt_q;
        if (state_q == S_DONE) job_cnt_d = job_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) job_cnt_q <= '0;
        else     job_cnt_q <= job_cnt_d;
    end

    assign job_cnt = job_cnt_q;
`endif

    assign load_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign arr_clr    = arr_clr_q;
    assign we         = we_q;
    assign a_out      = a_out_q;
    assign b_out      = b_out_q;

endmodule
